// File: rtl/sram_pkg.sv
// Shared types and default geometry for the burst SRAM controller.
package sram_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned LEN_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Command, write-beat and read-beat channels of the burst SRAM controller.
interface sram_burst_ctrl_if
    import sram_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
);

    logic              reqValid;
    logic              reqReady;
    logic              reqWrite;
    logic [ADDR_W-1:0] reqAddr;
    logic [LEN_W-1:0]  reqLen;
    logic              wrValid;
    logic              wrReady;
    logic [DATA_W-1:0] wrData;
    logic              rdValid;
    logic [DATA_W-1:0] rdData;
    logic              busy;
    logic              done;

    modport master (
        output reqValid, reqWrite, reqAddr, reqLen, wrValid, wrData,
        input  reqReady, wrReady, rdValid, rdData, busy, done
    );

    modport slave (
        input  reqValid, reqWrite, reqAddr, reqLen, wrValid, wrData,
        output reqReady, wrReady, rdValid, rdData, busy, done
    );

endinterface

// File: rtl/sram_array.sv
// Single-port word array: synchronous write, registered read with enable.
module sram_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Only the output register is reset; it holds between read issues.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst read/write controller: FSM, auto-incrementing address and beat counter.
module sram_burst_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clock,
    input  logic              nReset,
    sram_burst_ctrl_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q, done_d;
    logic              beat_step;
    logic              mem_we;
    logic              mem_re;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            mar_q      <= '0;
            beat_cnt_q <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mar_q      <= mar_d;
            beat_cnt_q <= beat_cnt_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mar_d      = mar_q;
        beat_cnt_d = beat_cnt_q;
        done_d     = 1'b0;
        beat_step  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.reqValid) begin
                    mar_d      = bus.reqAddr;
                    beat_cnt_d = bus.reqLen;
                    state_d    = bus.reqWrite ? WRITE : READ;
                end
            end
            WRITE:   beat_step = bus.wrValid;
            READ:    beat_step = 1'b1;
            default: state_d = IDLE;
        endcase
        // Read done lands with the last rdValid because both trail the final issue by one edge.
        if (beat_step) begin
            mar_d      = mar_q + ADDR_W'(1);
            beat_cnt_d = beat_cnt_q - LEN_W'(1);
            if (beat_cnt_q == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
        rd_valid_d = (state_q == READ);
    end

    always_comb begin
        bus.reqReady = (state_q == IDLE);
        bus.wrReady  = (state_q == WRITE);
        bus.busy     = (state_q != IDLE);
        bus.rdValid  = rd_valid_q;
        bus.done     = done_q;
        mem_we       = (state_q == WRITE) && bus.wrValid;
        mem_re       = (state_q == READ);
    end

    sram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clock),
        .rst_n (nReset),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mar_q),
        .wdata (bus.wrData),
        .rdata (bus.rdData)
    );

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Scoreboard bench for sram_burst_ctrl: bursts, stalls, wrap, back-to-back, reset abort.
module tb_sram_burst_ctrl;

    typedef struct {
        logic [15:0] data;
        int unsigned cyc;
        bit          last;
    } exp_t;

    logic        clock;
    logic        nReset;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned done_cnt;
    exp_t        sb[$];
    logic [15:0] model [2048];

    sram_burst_ctrl_if #(.DATA_W(16), .ADDR_W(11), .LEN_W(4)) bif ();

    sram_burst_ctrl #(
        .DATA_W (16),
        .ADDR_W (11),
        .LEN_W  (4)
    ) dut (
        .clock  (clock),
        .nReset (nReset),
        .bus    (bif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Read-beat monitor: every rdValid must match the head of the scoreboard.
    always @(negedge clock) begin
        if (nReset) begin
            if (bif.done) done_cnt++;
            if (bif.rdValid) begin
                if (sb.size() == 0) begin
                    check_val("rd_spurious", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("rd_data", bif.rdData, e.data);
                    check_val("rd_cycle", cyc, e.cyc);
                    check_val("rd_done", bif.done, e.last);
                end
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [10:0] addr, input logic [3:0] len,
                            output int unsigned t_acc);
        bit ok;
        ok = 0;
        bif.reqValid = 1'b1;
        bif.reqWrite = wr;
        bif.reqAddr  = addr;
        bif.reqLen   = len;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bif.reqReady) begin
                ok = 1;
                break;
            end
        end
        @(posedge clock);
        #1;
        t_acc = cyc;
        bif.reqValid = 1'b0;
        check_val("cmd_accept", ok, 1);
        check_val("busy_after_accept", bif.busy, 1);
    endtask

    task automatic do_write(input logic [10:0] addr, input logic [3:0] len,
                            input logic [15:0] base, input int unsigned stall);
        int unsigned t;
        int unsigned d0;
        logic [10:0] a;
        send_cmd(1'b1, addr, len, t);
        d0 = done_cnt;
        for (int unsigned i = 0; i <= len; i++) begin
            if (i > 0) begin
                for (int unsigned s = 0; s < stall; s++) begin
                    bif.wrValid = 1'b0;
                    bif.wrData  = 16'hDEAD;
                    @(negedge clock);
                    check_val("wr_stall_busy", bif.busy, 1);
                    @(posedge clock);
                    #1;
                end
            end
            bif.wrValid = 1'b1;
            bif.wrData  = base + 16'(i);
            @(negedge clock);
            check_val("wr_ready", bif.wrReady, 1);
            @(posedge clock);
            #1;
            a = addr + 11'(i);
            model[a] = base + 16'(i);
        end
        bif.wrValid = 1'b0;
        @(negedge clock);
        check_val("wr_done", bif.done, 1);
        check_val("wr_busy_end", bif.busy, 0);
        check_val("wr_reqready_end", bif.reqReady, 1);
        @(posedge clock);
        #1;
        check_val("wr_done_once", done_cnt - d0, 1);
    endtask

    task automatic do_read(input logic [10:0] addr, input logic [3:0] len, output int unsigned t);
        exp_t        e;
        logic [10:0] a;
        send_cmd(1'b0, addr, len, t);
        for (int unsigned i = 0; i <= len; i++) begin
            a      = addr + 11'(i);
            e.data = model[a];
            e.cyc  = t + 1 + i;
            e.last = (i == len);
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64 && sb.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        check_val("rd_drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t1;
        int unsigned t2;
        int unsigned d0;
        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        nReset        = 1'b0;
        bif.reqValid  = 1'b0;
        bif.reqWrite  = 1'b0;
        bif.reqAddr   = '0;
        bif.reqLen    = '0;
        bif.wrValid   = 1'b0;
        bif.wrData    = '0;

        #22;
        check_val("rst_reqready", bif.reqReady, 1);
        check_val("rst_wrready", bif.wrReady, 0);
        check_val("rst_rdvalid", bif.rdValid, 0);
        check_val("rst_rddata", bif.rdData, 0);
        check_val("rst_busy", bif.busy, 0);
        check_val("rst_done", bif.done, 0);
        #10;
        nReset = 1'b1;
        @(negedge clock);
        check_val("post_rst_reqready", bif.reqReady, 1);
        check_val("post_rst_busy", bif.busy, 0);
        check_val("post_rst_rdvalid", bif.rdValid, 0);
        check_val("post_rst_done", bif.done, 0);
        @(posedge clock);
        #1;

        do_write(11'h010, 4'd3, 16'hA000, 0);
        do_read(11'h010, 4'd3, t1);
        wait_drain();

        do_write(11'h040, 4'd3, 16'h1111, 0);
        do_write(11'h040, 4'd2, 16'hC000, 2);
        do_read(11'h040, 4'd3, t1);
        wait_drain();

        do_write(11'h7FE, 4'd3, 16'h0001, 0);
        do_read(11'h7FF, 4'd1, t1);
        wait_drain();
        do_read(11'h7FE, 4'd3, t1);
        wait_drain();

        d0 = done_cnt;
        do_read(11'h010, 4'd1, t1);
        do_read(11'h040, 4'd0, t2);
        check_val("b2b_accept_cycle", t2, t1 + 3);
        wait_drain();
        check_val("b2b_done_count", done_cnt - d0, 2);

        do_write(11'h100, 4'd7, 16'hB000, 0);
        do_read(11'h100, 4'd7, t1);
        for (int i = 0; i < 40 && sb.size() > 6; i++) begin
            @(posedge clock);
            #1;
        end
        check_val("abort_wait", sb.size(), 6);
        nReset = 1'b0;
        #1;
        check_val("abort_rdvalid", bif.rdValid, 0);
        check_val("abort_busy", bif.busy, 0);
        check_val("abort_reqready", bif.reqReady, 1);
        check_val("abort_done", bif.done, 0);
        check_val("abort_rddata", bif.rdData, 0);
        sb.delete();
        @(negedge clock);
        #2;
        nReset = 1'b1;
        @(posedge clock);
        #1;
        do_read(11'h100, 4'd7, t1);
        wait_drain();
        do_read(11'h010, 4'd3, t1);
        wait_drain();

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
